// File: rtl/klp32_step_pkg.sv
// klp32_step_pkg: shared FSM encoding and default timing constants
// for the KLP32 execution sequencer (klp32_step_ctrl, klp32_debounce).
package klp32_step_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_HALT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BREAK = 2'd3
    } stepState_e;

    localparam int DEFAULT_CLK_DIV         = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/klp32_debounce.sv
// klp32_debounce: counter debouncer for an already-synchronized level.
// Ports: clk, rst_n (async low), level (synced in), stable (out, resets 1).
module klp32_debounce
    import klp32_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic stable
);

    localparam int CW = cntWidth(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt;

    // A new level is accepted once it has differed from the
    // accepted one for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (level == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= level;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/klp32_step_ctrl.sv
// klp32_step_ctrl: core clock-enable sequencer (reset/halt/run/break).
// Ports: clk, reset_in (async low), run_sw, step_btn_n, pc, bp_addr,
// bp_valid -> cpu_en, cpu_reset, state, step_count.
// Macro KLP32_BREAKPOINT_EN enables the PC breakpoint and BREAK state.
module klp32_step_ctrl
    import klp32_step_pkg::*;
#(
    parameter int CLK_DIV         = DEFAULT_CLK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        run_sw,
    input  logic        step_btn_n,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
    output logic        cpu_en,
    output logic        cpu_reset,
    output logic [1:0]  state,
    output logic [31:0] step_count
);

    localparam int PW = cntWidth(CLK_DIV);

    logic [1:0]    runSyncQ;
    logic [1:0]    btnSyncQ;
    logic          runSync;
    logic          btnLevel;
    logic          btnPrev;
    logic          press;
    stepState_e    stateQ;
    stepState_e    stateD;
    logic          rstHeld;
    logic [PW-1:0] presc;
    logic          prescWrap;
    logic          pulseD;
    logic          cpuEnQ;
    logic [31:0]   stepCount;
    logic          bpHit;

    assign runSync = runSyncQ[1];

    klp32_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBtnDebounce (
        .clk   (clk),
        .rst_n (reset_in),
        .level (btnSyncQ[1]),
        .stable(btnLevel)
    );

    // One-cycle event on the debounced 1->0 edge only.
    assign press     = btnPrev & ~btnLevel;
    assign prescWrap = (presc == PW'(CLK_DIV - 1));

`ifdef KLP32_BREAKPOINT_EN
    assign bpHit = bp_valid && (pc == bp_addr);
`else
    logic unusedBp;
    assign unusedBp = ^{bp_valid, bp_addr, pc};
    assign bpHit    = 1'b0;
`endif

    always_comb begin
        stateD = stateQ;
        pulseD = 1'b0;
        unique case (stateQ)
            ST_RST: begin
                // rstHeld marks the second cycle out of reset
                if (rstHeld) begin
                    stateD = runSync ? ST_RUN : ST_HALT;
                end
            end
            ST_HALT: begin
                pulseD = press;
                if (runSync) begin
                    stateD = ST_RUN;
                end
            end
            ST_RUN: begin
                if (prescWrap) begin
                    if (bpHit) begin
                        stateD = ST_BREAK;
                    end else begin
                        pulseD = 1'b1;
                    end
                end
                if (!runSync) begin
                    stateD = ST_HALT;
                end
            end
            ST_BREAK: begin
                if (press) begin
                    pulseD = 1'b1;
                    stateD = runSync ? ST_RUN : ST_HALT;
                end else if (!runSync) begin
                    stateD = ST_HALT;
                end
            end
            default: begin
                stateD = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            runSyncQ  <= '0;
            btnSyncQ  <= '1;
            btnPrev   <= 1'b1;
            stateQ    <= ST_RST;
            rstHeld   <= 1'b0;
            presc     <= '0;
            cpuEnQ    <= 1'b0;
            stepCount <= '0;
        end else begin
            runSyncQ  <= {runSyncQ[0], run_sw};
            btnSyncQ  <= {btnSyncQ[0], step_btn_n};
            btnPrev   <= btnLevel;
            stateQ    <= stateD;
            rstHeld   <= (stateQ == ST_RST);
            // Held at zero outside RUN so every entry starts a full period.
            if (stateQ != ST_RUN || prescWrap) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
            cpuEnQ    <= pulseD;
            stepCount <= stepCount + 32'(pulseD);
        end
    end

    assign cpu_en     = cpuEnQ;
    assign cpu_reset  = (stateQ == ST_RST);
    assign state      = stateQ;
    assign step_count = stepCount;

endmodule

// File: tb/tb_klp32_step_ctrl.sv
// tb_klp32_step_ctrl: randomized self-checking bench for klp32_step_ctrl
// against an edge-indexed behavioural model (CLK_DIV=4, DEBOUNCE=3).
module tb_klp32_step_ctrl;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int M_RST = 0, M_HALT = 1, M_RUN = 2, M_BRK = 3;
`ifdef KLP32_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn_n = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] bp_addr = '0;
    logic        bp_valid = 1'b0;
    logic        cpu_en;
    logic        cpu_reset;
    logic [1:0]  state;
    logic [31:0] step_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    klp32_step_ctrl #(
        .CLK_DIV(DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset_in(reset_in),
        .run_sw(run_sw),
        .step_btn_n(step_btn_n),
        .pc(pc),
        .bp_addr(bp_addr),
        .bp_valid(bp_valid),
        .cpu_en(cpu_en),
        .cpu_reset(cpu_reset),
        .state(state),
        .step_count(step_count)
    );

    // Reference model: e counts clock edges since reset release; the
    // histories hold the input values seen at each edge (index = edge).
    int          e;
    bit          runH[$];
    bit          btnH[$];
    bit          sbH[$];
    bit          dbStable;
    int          fellAt;
    int          mState;
    int          runEntry;
    logic [31:0] expCount;
    logic [35:0] expVec;

    task automatic modelReset();
        e = 0;
        runH.delete();
        btnH.delete();
        sbH.delete();
        runH.push_back(1'b0);
        btnH.push_back(1'b1);
        sbH.push_back(1'b1);
        dbStable = 1'b1;
        fellAt = -10;
        mState = M_RST;
        runEntry = 0;
        expCount = '0;
        expVec = {1'b0, 1'b1, 2'd0, 32'd0};
    endtask

    task automatic modelStep();
        bit sr, sb, v, pressNow, allDiff, pulse;
        int ns, k, idx;
        e++;
        runH.push_back(run_sw);
        btnH.push_back(step_btn_n);
        sr = (e >= 3) ? runH[e-2] : 1'b0;
        sb = (e >= 3) ? btnH[e-2] : 1'b1;
        sbH.push_back(sb);
        pressNow = (fellAt == e - 1);
        allDiff = 1'b1;
        for (int i = 0; i < DEB; i++) begin
            idx = e - i;
            v = (idx >= 1) ? sbH[idx] : 1'b1;
            if (v == dbStable) allDiff = 1'b0;
        end
        if (allDiff) begin
            dbStable = ~dbStable;
            if (!dbStable) fellAt = e;
        end
        pulse = 1'b0;
        ns = mState;
        case (mState)
            M_RST: if (e == 2) ns = sr ? M_RUN : M_HALT;
            M_HALT: begin
                pulse = pressNow;
                if (sr) ns = M_RUN;
            end
            M_RUN: begin
                k = e - runEntry;
                if (k > 0 && k % DIV == 0) begin
                    if (BP_ON && bp_valid && pc == bp_addr) ns = M_BRK;
                    else pulse = 1'b1;
                end
                if (!sr) ns = M_HALT;
            end
            default: begin
                if (pressNow) begin
                    pulse = 1'b1;
                    ns = sr ? M_RUN : M_HALT;
                end else if (!sr) begin
                    ns = M_HALT;
                end
            end
        endcase
        if (ns == M_RUN && mState != M_RUN) runEntry = e;
        mState = ns;
        expCount = expCount + 32'(pulse);
        expVec = {pulse, mState == M_RST, 2'(mState), expCount};
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_in) modelStep();
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset_in = 1'b0;
        modelReset();
        repeat (2) tick();
        reset_in = 1'b1;
    endtask

    task automatic test_reset();
        int hi, pulses;
        #2 reset_in = 1'b0;
        modelReset();
        #1;
        total++;
        if ({cpu_en, cpu_reset, state, step_count} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_vals: got %h want %h",
                     {cpu_en, cpu_reset, state, step_count}, {1'b0, 1'b1, 2'd0, 32'd0});
        end
        @(negedge clk);
        reset_in = 1'b1;
        hi = int'(cpu_reset);
        pulses = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (i < 10) hi += int'(cpu_reset);
            pulses += int'(cpu_en);
            total++;
            if ({cpu_en, cpu_reset, state, step_count} !== expVec) begin
                bad++;
                $display("FAIL reset_cyc: got %h want %h",
                         {cpu_en, cpu_reset, state, step_count}, expVec);
            end
        end
        total++;
        if (hi != 2) begin
            bad++;
            $display("FAIL reset_len: got %0d cycles want 2", hi);
        end
        total++;
        if (pulses != 0 || state !== 2'd1) begin
            bad++;
            $display("FAIL halt_idle: got %0d pulses st=%0d want 0 st=1", pulses, state);
        end
    endtask

    task automatic test_run();
        int n;
        logic [31:0] start;
        run_sw = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 10) begin
            tick();
            n++;
            total++;
            if ({cpu_en, cpu_reset, state, step_count} !== expVec) begin
                bad++;
                $display("FAIL run_entry: got %h want %h",
                         {cpu_en, cpu_reset, state, step_count}, expVec);
            end
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL run_latency: got %0d want 3", n);
        end
        start = step_count;
        repeat (40) begin
            tick();
            total++;
            if ({cpu_en, cpu_reset, state, step_count} !== expVec) begin
                bad++;
                $display("FAIL run_cyc: got %h want %h",
                         {cpu_en, cpu_reset, state, step_count}, expVec);
            end
        end
        total++;
        if (step_count - start !== 32'd10) begin
            bad++;
            $display("FAIL run_count: got %0d want 10", step_count - start);
        end
    endtask

    task automatic test_step();
        int n, lat, pulses, seg;
        run_sw = 1'b0;
        n = 0;
        while (state !== 2'd1 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (state !== 2'd1) begin
            bad++;
            $display("FAIL halt_entry: got st=%0d want 1", state);
        end
        repeat (2) tick();
        lat = 0;
        pulses = 0;
        step_btn_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 11) step_btn_n = 1'b1;
            tick();
            if (cpu_en) begin
                pulses++;
                if (lat == 0) lat = i;
            end
            total++;
            if ({cpu_en, cpu_reset, state, step_count} !== expVec) begin
                bad++;
                $display("FAIL step_cyc: got %h want %h",
                         {cpu_en, cpu_reset, state, step_count}, expVec);
            end
        end
        total++;
        if (pulses != 1 || lat != 6) begin
            bad++;
            $display("FAIL step_press: got %0d pulses lat %0d want 1 lat 6", pulses, lat);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (i < 20) step_btn_n = ((i % 4) < 2) ? 1'b0 : 1'b1;
            else step_btn_n = 1'b1;
            tick();
            pulses += int'(cpu_en);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL step_bounce: got %0d pulses want 0", pulses);
        end
        seg = 0;
        for (int i = 0; i < 400; i++) begin
            if (seg == 0) begin
                step_btn_n = ~step_btn_n;
                seg = $urandom_range(1, 8);
            end
            seg--;
            tick();
            total++;
            if ({cpu_en, cpu_reset, state, step_count} !== expVec) begin
                bad++;
                $display("FAIL step_rand: got %h want %h",
                         {cpu_en, cpu_reset, state, step_count}, expVec);
            end
        end
        step_btn_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_breakpoint();
        bit sawBrk;
        int pcs[$];
        int n, pulses;
        applyReset();
        bp_valid = 1'b1;
        bp_addr = 32'h10;
        pc = '0;
        run_sw = 1'b1;
        step_btn_n = 1'b1;
        sawBrk = 1'b0;
        n = 0;
        while (!sawBrk && n < 60) begin
            tick();
            n++;
            total++;
            if ({cpu_en, cpu_reset, state, step_count} !== expVec) begin
                bad++;
                $display("FAIL bp_cyc: got %h want %h",
                         {cpu_en, cpu_reset, state, step_count}, expVec);
            end
            if (cpu_en) begin
                pcs.push_back(int'(pc));
                pc = pc + 32'd4;
            end
            if (state === 2'd3) sawBrk = 1'b1;
        end
`ifdef KLP32_BREAKPOINT_EN
        total++;
        if (!sawBrk || pc !== 32'h10 || pcs.size() != 4 || pcs[3] != 12) begin
            bad++;
            $display("FAIL bp_hit: brk=%0b pc=%h pulses=%0d want brk=1 pc=10 pulses=4",
                     sawBrk, pc, pcs.size());
        end
        step_btn_n = 1'b0;
        pulses = 0;
        n = 0;
        while (state === 2'd3 && n < 20) begin
            tick();
            n++;
            pulses += int'(cpu_en);
            if (cpu_en) pc = pc + 32'd4;
        end
        step_btn_n = 1'b1;
        total++;
        if (pulses != 1 || state !== 2'd2) begin
            bad++;
            $display("FAIL bp_resume: got %0d pulses st=%0d want 1 st=2", pulses, state);
        end
`else
        total++;
        if (sawBrk || pcs.size() < 10 || pc <= 32'h14) begin
            bad++;
            $display("FAIL bp_off: brk=%0b pulses=%0d pc=%h want no brk past 0x10",
                     sawBrk, pcs.size(), pc);
        end
`endif
        bp_valid = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int seg;
        applyReset();
        bp_addr = 32'h8;
        seg = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) run_sw = ~run_sw;
            if (seg == 0) begin
                step_btn_n = ~step_btn_n;
                seg = $urandom_range(1, 9);
            end
            seg--;
            pc = 32'($urandom_range(0, 3) * 4);
            bp_valid = ($urandom_range(0, 3) != 0);
            tick();
            total++;
            if ({cpu_en, cpu_reset, state, step_count} !== expVec) begin
                bad++;
                $display("FAIL rand_cyc %0d: got %h want %h", i,
                         {cpu_en, cpu_reset, state, step_count}, expVec);
            end
        end
        bp_valid = 1'b0;
        step_btn_n = 1'b1;
    endtask

    task automatic test_reset_midrun();
        int n;
        run_sw = 1'b1;
        n = 0;
        while (!(mState == M_RUN && (e - runEntry) % DIV == 3) && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (state !== 2'd2 || n >= 40) begin
            bad++;
            $display("FAIL midrun_wait: got st=%0d want 2 at count 3", state);
        end
        reset_in = 1'b0;
        modelReset();
        #1;
        total++;
        if ({cpu_en, cpu_reset, state, step_count} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
            bad++;
            $display("FAIL midrun_async: got %h want %h",
                     {cpu_en, cpu_reset, state, step_count}, {1'b0, 1'b1, 2'd0, 32'd0});
        end
        repeat (3) begin
            tick();
            total++;
            if ({cpu_en, cpu_reset, state, step_count} !== expVec) begin
                bad++;
                $display("FAIL midrun_hold: got %h want %h",
                         {cpu_en, cpu_reset, state, step_count}, expVec);
            end
        end
        reset_in = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        modelReset();
        test_reset();
        test_run();
        test_step();
        test_breakpoint();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/klp32_step_ctrl.md
# klp32_step_ctrl

Execution sequencer for the KLP32V1 core on the DE10-Lite. Generates the core's single-cycle clock-enable from the board clock, either free-running at a prescaled rate or one instruction per debounced push-button press. Holds the core in a cleanly released reset and optionally halts on a PC breakpoint. Sits between the board I/O and the processor instance in the top level, replacing any ad-hoc derived clock.

## Interface
- CLK_DIV, 50_000_000: board cycles per enable pulse in RUN (1 Hz at 50 MHz); legal ≥1
- DEBOUNCE_CYCLES, 500_000: stable cycles required to accept a button level change (10 ms); legal ≥1
- clk  in  1  board clock; all logic on rising edge
- reset_in  in  1  asynchronous, active-low reset (board button, low when pressed)
- run_sw  in  1  raw slide switch; 1 = free-run, 0 = halt/single-step
- step_btn_n  in  1  raw push button, active-low
- pc  in  32  current PC from the core
- bp_addr  in  32  breakpoint address
- bp_valid  in  1  breakpoint armed
- cpu_en  out  1  one-cycle enable; core advances one instruction per high cycle
- cpu_reset  out  1  active-high reset to core
- state  out  2  current FSM state (klp32_step_pkg encoding)
- step_count  out  32  number of cpu_en pulses since reset

## Operation
- States: RST=0, HALT=1, RUN=2, BREAK=3.
- run_sw and step_btn_n pass through 2-flop synchronizers; step_btn_n then through the debouncer. A "press" = debounced level falling 1→0; exactly one press event (one cycle) per press, none on release.
- RST: cpu_reset=1 for exactly 2 cycles after reset_in deasserts, then → RUN if synced run_sw=1, else HALT.
- HALT: cpu_en=1 for one cycle per press. Synced run_sw=1 → RUN.
- RUN: prescaler counts 0..CLK_DIV-1, cleared on RUN entry; cpu_en=1 on the cycle count==CLK_DIV-1. run_sw=0 → HALT (no further pulse; a pulse in the same cycle is still issued). Presses ignored.
- BREAK (macro only): no pulses. Press → one cpu_en pulse, then → RUN if run_sw=1 else HALT. run_sw falling → HALT.
- step_count increments on every cpu_en cycle; wraps 0xFFFF_FFFF→0.
- cpu_en and cpu_reset are never high together.

## Timing
- Reset values: cpu_en=0, cpu_reset=1, state=RST, step_count=0, prescaler=0, debouncer output=1 (released).
- run_sw → state change: 3 cycles (2 sync + register).
- Press latency: button edge to cpu_en = 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- CLK_DIV=1: cpu_en high every cycle in RUN.
- First RUN pulse arrives CLK_DIV cycles after RUN entry.
- Breakpoint check: in RUN on the cycle a pulse would fire, if bp_valid && pc==bp_addr, suppress the pulse and → BREAK next cycle. Instruction at bp_addr is not executed.
- reset_in asserted at any time: all outputs to reset values asynchronously; any pending pulse or press is discarded.

## Configuration
- KLP32_BREAKPOINT_EN defined: breakpoint compare and BREAK state present.
- Undefined: bp_addr/bp_valid ports remain but are ignored; BREAK unreachable; state never reads 3.

## Structure
- Package klp32_step_pkg: state enum (2-bit, encodings above), DEFAULT_CLK_DIV, DEFAULT_DEBOUNCE_CYCLES constants.
- Sub-module klp32_debounce (sync-input, counter-based, parameter DEBOUNCE_CYCLES, reset output 1); instantiated once for step_btn_n.
- Prescaler width = $clog2(CLK_DIV) with a minimum of 1.

## Test plan (CLK_DIV=4, DEBOUNCE_CYCLES=3)
- Reset release with run_sw=0 → cpu_reset high exactly 2 cycles, state=HALT, no cpu_en for 100 cycles.
- run_sw=1 held → state=RUN; cpu_en every 4th cycle; step_count=10 after 40 cycles in RUN.
- HALT, step_btn_n low for 10 cycles then high → exactly one cpu_en, 6 cycles after falling edge; bounce pulses of 2 cycles → none.
- Macro on, bp_valid=1, bp_addr=0x0000_0010, pc stepping by 4 from 0 → pulses at pc 0,4,8,0xC, then state=BREAK with pc=0x10; one press → one pulse, back to RUN.
- reset_in low mid-RUN on prescaler count 3 → cpu_en stays 0, step_count=0, cpu_reset=1 immediately.
- Macro off, same breakpoint stimulus → no BREAK, pulses continue past 0x10.
